pkt_tx_gen: RTL and testbench

//  Packet source driving the MAC's user-side transmit interface (pkt_tx_*): the sending end of the

---
 rtl/pkt_tx_gen.sv | 129 ++++++++++++
 tb/tb_pkt_tx_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_gen.sv
// pkt_tx_gen: burst frame source for the MAC pkt_tx interface with a deterministic byte pattern,
// pkt_tx_full backpressure and a programmable inter-frame gap.
module pkt_tx_gen #(
  parameter int MIN_LEN = 8,
  parameter int LEN_W   = 14,
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 8
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_num_frames,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             pkt_tx_full,
  output logic [63:0]      pkt_tx_data,
  output logic             pkt_tx_val,
  output logic             pkt_tx_sop,
  output logic             pkt_tx_eop,
  output logic [2:0]       pkt_tx_mod,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent
);
  localparam int WW = LEN_W - 3;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, len_c, eff_len;
  logic [CNT_W-1:0] num_q, num_d, eff_num, fs_q, fs_d, eff_f;
  logic [GAP_W-1:0] gap_q, gap_d, eff_gap, gcnt_q, gcnt_d;
  logic [WW-1:0] w_q, w_d;
  logic [63:0] data_q, data_d, word;
  logic [2:0] mod_q, mod_d;
  logic stop_q, stop_d, busy_q, busy_d, done_q, done_d;
  logic val_q, val_d, sop_q, sop_d, eop_q, eop_d;
  logic idle, start, issue, last, stop_now, remain;
  // On the accepting edge the live cfg_* values drive the first word directly
  assign idle     = state_q == IDLE;
  assign start    = idle && cfg_start && !busy_q;
  assign len_c    = (cfg_len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : cfg_len;
  assign eff_len  = start ? len_c : len_q;
  assign eff_num  = start ? cfg_num_frames : num_q;
  assign eff_gap  = start ? cfg_gap : gap_q;
  assign eff_f    = start ? '0 : fs_q;
  assign issue    = (start || state_q == SEND) && !pkt_tx_full;
  assign last     = ({1'b0, w_q, 3'b000} + (LEN_W+1)'(8)) >= {1'b0, eff_len};
  assign stop_now = !idle && (stop_q || cfg_stop);
  assign remain   = eff_num == '0 || eff_f + CNT_W'(1) != eff_num;
  always_comb begin
    word = '0;
    for (int j = 0; j < 8; j++)
      word[63-8*j -: 8] = ({w_q, 3'(j)} < eff_len) ? eff_f[7:0] + {w_q[4:0], 3'(j)} : 8'h00;
  end
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    num_d   = num_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    w_d     = issue ? (last ? '0 : w_q + WW'(1)) : w_q;
    fs_d    = eff_f + CNT_W'(issue && last);
    data_d  = issue ? word : data_q;
    mod_d   = (issue && last) ? eff_len[2:0] : 3'd0;
    val_d   = issue;
    sop_d   = issue && w_q == '0;
    eop_d   = issue && last;
    busy_d  = start || !idle;
    done_d  = idle && busy_q;
    if (start) begin
      len_d   = len_c;
      num_d   = cfg_num_frames;
      gap_d   = cfg_gap;
      state_d = SEND;
    end
    if (issue && last) begin
      state_d = (!remain || stop_now) ? IDLE : (eff_gap == '0) ? SEND : GAP;
      gcnt_d  = eff_gap;
    end
    if (state_q == GAP) begin
      state_d = stop_now ? IDLE : (gcnt_q == GAP_W'(1)) ? SEND : GAP;
      gcnt_d  = gcnt_q - GAP_W'(1);
    end
    stop_d = state_d != IDLE && stop_now;
  end
  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      num_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      fs_q    <= '0;
      w_q     <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      val_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      num_q   <= num_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      fs_q    <= fs_d;
      w_q     <= w_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      val_q   <= val_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end
  assign pkt_tx_data = data_q;
  assign pkt_tx_val  = val_q;
  assign pkt_tx_sop  = sop_q;
  assign pkt_tx_eop  = eop_q;
  assign pkt_tx_mod  = mod_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = fs_q;
endmodule

// File: tb/tb_pkt_tx_gen.sv
// tb_pkt_tx_gen: drives bursts into pkt_tx_gen and checks every output cycle against an
// expected word stream built from the frame/pattern rules.
module tb_pkt_tx_gen;
  logic clk_156m25 = 1'b0;
  logic reset_156m25_n = 1'b0;
  logic cfg_start = 1'b0;
  logic cfg_stop = 1'b0;
  logic pkt_tx_full = 1'b0;
  logic [13:0] cfg_len = '0;
  logic [15:0] cfg_num_frames = '0;
  logic [7:0] cfg_gap = '0;
  logic [63:0] pkt_tx_data;
  logic pkt_tx_val, pkt_tx_sop, pkt_tx_eop, busy, done;
  logic [2:0] pkt_tx_mod;
  logic [15:0] frames_sent;
  int checks = 0;
  int failures = 0;
  int stalls;
  typedef struct {logic [63:0] d; logic sop; logic eop; logic [2:0] mod;} word_t;
  word_t exp_q[$];
  logic [63:0] got[$];

  always #5 clk_156m25 = ~clk_156m25;

  pkt_tx_gen dut (
    .clk_156m25(clk_156m25), .reset_156m25_n(reset_156m25_n),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_len(cfg_len),
    .cfg_num_frames(cfg_num_frames), .cfg_gap(cfg_gap), .pkt_tx_full(pkt_tx_full),
    .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
    .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .busy(busy), .done(done),
    .frames_sent(frames_sent)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int f, input int w, input int l);
    logic [63:0] r = '0;
    for (int j = 0; j < 8; j++)
      if (8*w + j < l) r[63-8*j -: 8] = 8'((f + 8*w + j) % 256);
    return r;
  endfunction

  // full_mode: 0 never, 1 random, 2 high for loop cycles [fa,fb)
  task automatic burst(input int len, input int num, input int gap, input int nfr,
                       input int full_mode, input int fa, input int fb,
                       input int stop_f, input int rst_at);
    int l, nw, since, after, fs, cur_f;
    bit running, full_e, ev;
    word_t e;
    l = (len < 8) ? 8 : len;
    nw = (l + 7) / 8;
    exp_q.delete();
    got.delete();
    stalls = 0;
    for (int f = 0; f < nfr; f++)
      for (int w = 0; w < nw; w++) begin
        e.d = pat(f, w, l);
        e.sop = (w == 0);
        e.eop = (w == nw - 1);
        e.mod = (w == nw - 1) ? 3'(l % 8) : 3'd0;
        exp_q.push_back(e);
      end
    cfg_len = 14'(len);
    cfg_num_frames = 16'(num);
    cfg_gap = 8'(gap);
    cfg_start = 1'b1;
    running = 1'b1;
    since = 1000;
    after = -1;
    fs = 0;
    cur_f = -1;
    for (int cyc = 0; running && cyc < 2000; cyc++) begin
      pkt_tx_full = (full_mode == 1) ? ($urandom_range(3) == 0) :
                    (full_mode == 2) ? (cyc >= fa && cyc < fb) : 1'b0;
      full_e = pkt_tx_full;
      if (cyc == rst_at) reset_156m25_n = 1'b0;
      @(posedge clk_156m25);
      #1;
      cfg_start = 1'b0;
      cfg_stop = 1'b0;
      if (cyc == rst_at) begin
        check("rst_out", {pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
                          busy, done, frames_sent} != '0, 1'b0);
        reset_156m25_n = 1'b1;
        running = 1'b0;
      end else begin
        since++;
        if (after >= 0) after++;
        ev = exp_q.size() > 0 && since > gap && !full_e;
        if (exp_q.size() > 0 && since > gap && full_e) stalls++;
        check("val", pkt_tx_val, ev);
        if (pkt_tx_val && ev) begin
          e = exp_q.pop_front();
          got.push_back(pkt_tx_data);
          if (e.eop) fs++;
          check("data", pkt_tx_data, e.d);
          check("ctl", {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, {e.sop, e.eop, e.mod});
          since = e.eop ? 0 : 1000;
          if (e.sop) cur_f++;
          if (e.sop && cur_f == stop_f) cfg_stop = 1'b1;
          if (exp_q.size() == 0) after = 0;
        end else begin
          check("idle_ctl", {pkt_tx_sop, pkt_tx_eop}, 2'b00);
        end
        check("frames_sent", frames_sent, fs);
        check("busy", busy, after < 1);
        check("done", done, after == 1);
        if (after == 1) running = 1'b0;
        else if (full_mode == 1 && $urandom_range(7) == 0) begin
          cfg_start = 1'b1;
          cfg_len = 14'($urandom);
          cfg_num_frames = 16'($urandom);
          cfg_gap = 8'($urandom);
        end
      end
    end
    pkt_tx_full = 1'b0;
    check("finished", running, 1'b0);
  endtask

  initial begin
    int len, num, gap;
    repeat (3) @(posedge clk_156m25);
    #1;
    check("rst_val", {pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, '0);
    check("rst_data", pkt_tx_data, '0);
    check("rst_stat", {busy, done, frames_sent}, '0);
    reset_156m25_n = 1'b1;
    burst(64, 1, 0, 1, 0, 0, 0, -1, -1);
    check("n64", got.size(), 8);
    if (got.size() == 8) begin
      check("w0_64", got[0], 64'h0001020304050607);
      check("w7_64", got[7], 64'h38393A3B3C3D3E3F);
    end
    burst(65, 1, 0, 1, 0, 0, 0, -1, -1);
    check("n65", got.size(), 9);
    if (got.size() == 9) check("w8_65", got[8], 64'h4000000000000000);
    burst(3, 1, 0, 1, 0, 0, 0, -1, -1);
    check("n3", got.size(), 1);
    if (got.size() == 1) check("w0_3", got[0], 64'h0001020304050607);
    burst(64, 1, 0, 1, 2, 3, 8, -1, -1);
    check("stalls", stalls, 5);
    check("n64bp", got.size(), 8);
    burst(24, 3, 4, 3, 0, 0, 0, -1, -1);
    check("n_gap", got.size(), 9);
    if (got.size() == 9) check("f1w0", got[3], 64'h0102030405060708);
    burst(32, 0, 0, 3, 0, 0, 0, 2, -1);
    check("stop_fs", frames_sent, 3);
    burst(64, 1, 0, 1, 0, 0, 0, -1, 3);
    burst(16, 1, 0, 1, 0, 0, 0, -1, -1);
    if (got.size() == 2) check("restart_w0", got[0], 64'h0001020304050607);
    check("restart_n", got.size(), 2);
    for (int i = 0; i < 12; i++) begin
      len = $urandom_range(40, 1);
      num = $urandom_range(4, 1);
      gap = $urandom_range(5, 0);
      burst(len, num, gap, num, 1, 0, 0, -1, -1);
    end
    for (int i = 0; i < 4; i++) begin
      len = $urandom_range(40, 9);
      gap = $urandom_range(3, 0);
      num = $urandom_range(2, 0);
      burst(len, 0, gap, num + 1, 1, 0, 0, num, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
